// File: rtl/sopc_pio_in_irq_pkg.sv
// Shared register map and edge-mode encodings for the debounced PIO input block.
package sopc_pio_in_irq_pkg;

   // Avalon-MM word addresses
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // EDGE_MODE parameter encodings
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // Qualify a per-bit level change by the selected edge mode.
   function automatic logic edge_qualify(input int mode, input logic cur, input logic prev);
      logic hit;
      hit = 1'b0;
      if (mode == EDGE_RISING) begin
         hit = cur & ~prev;
      end else if (mode == EDGE_FALLING) begin
         hit = ~cur & prev;
      end else begin
         hit = cur ^ prev;
      end
      return hit;
   endfunction

endpackage

// File: rtl/sopc_pio_in_irq_debounce_bit.sv
// One input channel: 2-flop synchroniser followed by a saturating debounce counter.
module pio_debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic stable
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // The accepting cycle is the one where the count would reach DEBOUNCE_CYCLES,
   // so the counter itself never has to hold that value and cannot wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] count;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= INIT_LEVEL;
         sync_p1 <= INIT_LEVEL;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
      end
   end

   // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         stable <= INIT_LEVEL;
      end else if (sync_p1 == stable) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         stable <= sync_p1;
         count  <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sopc_pio_in_irq.sv
// Debounced PIO input port with edge capture, interrupt mask and Avalon-MM slave.
module sopc_pio_in_irq
   import sopc_pio_in_irq_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter int               EDGE_MODE       = 1,
   parameter logic [WIDTH-1:0] INIT_LEVEL      = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;
   logic [31:0]      rd_mux;
   logic             wr_en;
   logic             unused_bits;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT_LEVEL      (INIT_LEVEL[i])
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .din    (in_port[i]),
         .stable (stable[i])
      );
   end

   // Write data bits above the channel count have no destination.
   if (WIDTH < 32) begin : g_wd_spare
      assign unused_bits = ^writedata[31:WIDTH];
   end else begin : g_wd_full
      assign unused_bits = 1'b0;
   end

   assign wr_en = chipselect & ~write_n;

   // Edge detection, write-1-to-clear decode and read mux
   always_comb begin
      edge_det = '0;
      edge_clr = '0;
      rd_mux   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_det[i] = edge_qualify(EDGE_MODE, stable[i], stable_d[i]);
      end
      if (wr_en && (address == ADDR_EDGE)) begin
         edge_clr = writedata[WIDTH-1:0];
      end
      case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
         ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = capture;
         default:   rd_mux = '0;
      endcase
   end

   // Register file, edge capture (set wins over clear), interrupt and read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d <= INIT_LEVEL;
         mask     <= '0;
         capture  <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         stable_d <= stable;
         capture  <= (capture & ~edge_clr) | edge_det;
         if (wr_en && (address == ADDR_MASK)) begin
            mask <= writedata[WIDTH-1:0];
         end
         irq      <= |(capture & mask);
         readdata <= chipselect ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_sopc_pio_in_irq.sv
// Scoreboard bench for sopc_pio_in_irq with a window-based debounce reference model.
module tb_sopc_pio_in_irq;

   localparam int             W    = 4;
   localparam int             D    = 4;
   localparam int             EM   = 1;
   localparam logic [W-1:0]   INIT = 4'hF;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata;
   logic          irq;

   always #5 clk = ~clk;

   sopc_pio_in_irq #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .EDGE_MODE       (EM),
      .INIT_LEVEL      (INIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   int checks = 0;
   int passes = 0;

   // reference model state
   logic [W-1:0]  m_stable;
   logic [W-1:0]  m_prev;
   logic [W-1:0]  m_mask;
   logic [W-1:0]  m_cap;
   logic          m_irq;
   logic [W-1:0]  hist[$];
   logic [31:0]   exp_q[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void model_reset();
      m_stable = INIT;
      m_prev   = INIT;
      m_mask   = '0;
      m_cap    = '0;
      m_irq    = 1'b0;
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_front(INIT);
      exp_q.delete();
   endfunction

   // One active clock edge of the reference model, using the inputs present at that edge.
   function automatic void model_step();
      logic [W-1:0] changed, edges, clr, ns, h;
      logic [31:0]  rv;
      logic         wr, all_diff;
      wr = chipselect && !write_n;
      if (chipselect && write_n) begin
         rv = '0;
         if (address == 2'd0) rv[W-1:0] = m_stable;
         else if (address == 2'd2) rv[W-1:0] = m_mask;
         else if (address == 2'd3) rv[W-1:0] = m_cap;
         exp_q.push_back(rv);
      end
      changed = m_stable ^ m_prev;
      if (EM == 0)      edges = changed & m_stable;
      else if (EM == 1) edges = changed & ~m_stable;
      else              edges = changed;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_irq = |(m_cap & m_mask);
      m_cap = (m_cap & ~clr) | edges;
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_prev = m_stable;
      // a bit flips once the D most recent synchronised samples all disagree with it
      ns = m_stable;
      for (int b = 0; b < W; b++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= D; j++) begin
            h = hist[j];
            if (h[b] == m_stable[b]) all_diff = 1'b0;
         end
         if (all_diff) ns[b] = ~m_stable[b];
      end
      m_stable = ns;
      hist.push_front(in_port);
      void'(hist.pop_back());
   endfunction

   // monitor: irq every cycle, read data whenever a read response is due
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset === 1'b0) begin
         chk("irq", {31'd0, irq}, {31'd0, m_irq});
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("readdata", readdata, e);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic rd(input logic [1:0] a);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      cyc();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      cyc();
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      logic found;
      int   r;
      reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = INIT;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;

      // reset values visible through the register map
      rd(2'd0); rd(2'd2); rd(2'd3); rd(2'd1);

      // bit 3 falls with only bit 3 enabled, then clear it
      wr(2'd2, 32'h8);
      in_port = 4'h7;
      for (int i = 0; i < 9; i++) rd(2'd0);
      rd(2'd3);
      wr(2'd3, 32'h8);
      idle(2);
      rd(2'd3);

      // settle to 0000, clear captures, then 0000->0001 with per-cycle reads
      in_port = 4'h0;
      idle(10);
      wr(2'd3, 32'hF);
      in_port = 4'h1;
      for (int i = 0; i < 9; i++) rd(2'd0);
      rd(2'd3);

      // 3-cycle glitch on bit 2 must not be accepted
      wr(2'd2, 32'hF);
      in_port = 4'h5;
      idle(3);
      in_port = 4'h1;
      for (int i = 0; i < 8; i++) rd(2'd0);
      rd(2'd3);

      // pending capture with mask 0, then enable it
      wr(2'd2, 32'h0);
      in_port = 4'h3;
      idle(8);
      in_port = 4'h1;
      idle(8);
      rd(2'd3);
      wr(2'd2, 32'h2);
      idle(2);
      wr(2'd3, 32'h2);
      idle(2);

      // edge on bit 0 coinciding with a clear of bit 0
      wr(2'd3, 32'hF);
      in_port = 4'h0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_stable[0] != m_prev[0]) begin
            wr(2'd3, 32'h1);
            found = 1'b1;
         end else begin
            cyc();
         end
      end
      chk("set_wins_edge_seen", {31'd0, found}, 32'h1);
      rd(2'd3);
      rd(2'd3);

      // reset in the middle of a debounce
      wr(2'd2, 32'hF);
      in_port = 4'h5;
      idle(3);
      do_reset();
      in_port = INIT;
      rd(2'd0); rd(2'd2); rd(2'd3);
      idle(10);
      rd(2'd3); rd(2'd0);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 11) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
         r = $urandom_range(0, 9);
         if (r <= 4)      rd(2'($urandom_range(0, 3)));
         else if (r == 5) wr(2'd2, $urandom);
         else if (r == 6) wr(2'd3, $urandom);
         else if (r == 7) wr(2'($urandom_range(0, 1)), $urandom);
         else             cyc();
      end

      idle(3);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sopc_pio_in_irq.md
SOPC_PIO_IN_IRQ -- requirements
Module: sopc_pio_in_irq

Interface
REQ-001 Parameter WIDTH, default 4: number of input channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a level is accepted, legal range 1..65535.
REQ-003 Parameter EDGE_MODE, default 1: 0 = rising, 1 = falling, 2 = any edge captured.
REQ-004 Parameter INIT_LEVEL, default all-zero WIDTH-bit vector: reset value of the synchroniser and debounced level.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address  in  2  Avalon-MM word address.
REQ-008 chipselect  in  1  Avalon-MM slave select.
REQ-009 write_n  in  1  Avalon-MM write strobe, active-low.
REQ-010 writedata  in  32  Avalon-MM write data.
REQ-011 in_port  in  WIDTH  asynchronous external inputs (buttons/switches).
REQ-012 readdata  out  32  registered read data; bits above WIDTH read 0.
REQ-013 irq  out  1  level interrupt request, active-high.

Function
REQ-014 Each in_port bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 Per bit, a debounce counter SHALL count cycles where synced != stable, clear when synced == stable, and update stable to synced when the count reaches DEBOUNCE_CYCLES (counter then clears).
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never wrap.
REQ-017 Latency: a clean in_port change SHALL appear in stable exactly 2+DEBOUNCE_CYCLES cycles later and in readdata one further cycle after a read of address 0.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL NOT change stable or set edge capture.
REQ-019 Edge detect SHALL compare stable with its one-cycle-delayed copy and qualify by EDGE_MODE.
REQ-020 Register map: addr 0 = stable (RO); addr 1 = reads 0, writes ignored; addr 2 = irq mask (RW, WIDTH bits); addr 3 = edge capture (read; write-1-to-clear per bit).
REQ-021 readdata SHALL update every clock with the muxed value for the current address, gated by chipselect; read latency 1 cycle.
REQ-022 Writes SHALL occur when chipselect=1 and write_n=0 in the same cycle.
REQ-023 An edge detected in the same cycle as a write-1-to-clear of that bit SHALL leave the bit set (set wins).
REQ-024 irq SHALL equal OR(edge_capture AND mask), registered; asserted one cycle after the capture bit sets or the mask bit is written.
REQ-025 irq SHALL deassert one cycle after the last enabled capture bit is cleared or masked.

Reset
REQ-026 On reset: synchroniser flops and stable = INIT_LEVEL; delayed copy = INIT_LEVEL; counters = 0; mask = 0; edge capture = 0; readdata = 0; irq = 0.
REQ-027 Reset SHALL take effect asynchronously; release SHALL be used synchronously to clk.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be captured from the reset transition itself.

Structure
REQ-029 Shared package SHALL hold register-address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3) and EDGE_MODE encodings.
REQ-030 Per-bit synchroniser plus debouncer SHALL be one sub-module, pio_debounce_bit, instantiated WIDTH times via generate.

Verification
REQ-031 WIDTH=4, DEBOUNCE_CYCLES=4: in_port 0000->0001 held -> read addr 0 returns 0x1; stable changes exactly 6 cycles after input change.
REQ-032 3-cycle pulse on bit 2 with DEBOUNCE_CYCLES=4 -> stable, edge capture and irq unchanged.
REQ-033 EDGE_MODE=1, mask=0x8: bit 3 falls 1->0 (debounced) -> addr 3 reads 0x8, irq=1; write 0x8 to addr 3 -> capture reads 0x0, irq=0 next cycle.
REQ-034 Edge on bit 0 in the same cycle as write 0x1 to addr 3 -> capture bit 0 stays 1.
REQ-035 Mask=0, capture=0x2 pending -> irq=0; write mask 0x2 -> irq=1 one cycle later.
REQ-036 Assert reset mid-debounce with INIT_LEVEL=0xF -> all registers at reset values, addr 0 reads 0xF, no capture after release.
